// File: rtl/io_xfer_seq.sv
// Drum I/O transfer sequencer: stages the M19<->MZ band exchange and gates 4-bit digits by band position.
// Outputs decode registered state only; device handshake via DREQ/DACK holds the sequence indefinitely.
module io_xfer_seq (
    input  logic       CLOCK,
    input  logic       rst,
    input  logic       T0,
    input  logic       T29,
    input  logic       W0,
    input  logic       START,
    input  logic [1:0] MODE,
    input  logic [4:0] NDIG,
    input  logic       DACK,
    input  logic       ABORT,
    output logic       OE,
    output logic       OG,
    output logic       SLOW_OUT,
    output logic       FAST_OUT,
    output logic       IN,
    output logic       READY,
    output logic       DREQ,
    output logic       DSTB,
    output logic       DONE,
    output logic [4:0] DIG
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_SLOT = 3'd3;
    localparam logic [2:0] S_GATE = 3'd4;
    localparam logic [2:0] S_HOLD = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam logic [1:0] M_SLOW = 2'b00;
    localparam logic [1:0] M_FAST = 2'b01;
    localparam logic [1:0] M_IN   = 2'b10;
    localparam logic [1:0] M_BAD  = 2'b11;

    localparam logic [6:0] WC_LAST  = 7'd107;
    localparam logic [6:0] POS_LAST = 7'd115;
    localparam logic [6:0] HOLD_CYC = 7'd120;

    logic [2:0] state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [4:0] ndig_q, ndig_d;
    logic [4:0] dig_q, dig_d, dig_inc, dig_lim;
    logic [6:0] wc_q, wc_d, pos_q, pos_d, pos_cur;
    logic [6:0] cnt_q, cnt_d, slot_pos;
    logic       hs_q, hs_d;
    logic       is_in, is_fast, need_hs;

    // wc_d / pos_cur are the word and position of the current bit time; T0&W0 marks word 00, position 0.
    always_comb begin
        if (T0 && W0)
            wc_d = '0;
        else if (T0)
            wc_d = (wc_q == WC_LAST) ? '0 : wc_q + 7'd1;
        else
            wc_d = wc_q;
        pos_cur = (T0 && W0) ? '0 : pos_q;
        pos_d   = (pos_cur == POS_LAST) ? '0 : pos_cur + 7'd1;
    end

    assign is_in    = (mode_q == M_IN);
    assign is_fast  = (mode_q == M_FAST);
    assign need_hs  = !is_fast;
    assign dig_inc  = dig_q + 5'd1;
    assign dig_lim  = (ndig_q == 5'd0) ? 5'd29 : ndig_q;
    assign slot_pos = (dig_q == 5'd0) ? POS_LAST : {dig_q, 2'b00} - 7'd1;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        ndig_d  = ndig_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        hs_d    = hs_q;
        case (state_q)
            S_IDLE: begin
                if (START && MODE != M_BAD) begin
                    mode_d  = MODE;
                    ndig_d  = NDIG;
                    cnt_d   = '0;
                    hs_d    = 1'b0;
                    state_d = (MODE == M_IN) ? S_SLOT : S_ARM;
                end
            end
            S_ARM: begin
                if (T29 && wc_d == WC_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // Own cycle count so a mid-load resync of POS cannot stretch or cut the window.
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == POS_LAST) begin
                    cnt_d   = '0;
                    hs_d    = 1'b0;
                    state_d = is_in ? S_DONE : S_SLOT;
                end
            end
            S_SLOT: begin
                if (need_hs && !hs_q) begin
                    if (DACK)
                        hs_d = 1'b1;
                    else if (cnt_q == HOLD_CYC - 7'd1)
                        state_d = S_HOLD;
                    else
                        cnt_d = cnt_q + 7'd1;
                end else if (pos_cur == slot_pos) begin
                    cnt_d   = '0;
                    state_d = S_GATE;
                end
            end
            S_HOLD: begin
                if (DACK) begin
                    hs_d    = 1'b1;
                    state_d = S_SLOT;
                end
            end
            S_GATE: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == 7'd3) begin
                    dig_d = dig_inc;
                    cnt_d = '0;
                    hs_d  = 1'b0;
                    // The last gate cycle sits on the next digit's slot position, so fast mode chains directly.
                    if (dig_inc == dig_lim)
                        state_d = is_in ? S_ARM : S_DONE;
                    else if (is_fast)
                        state_d = S_GATE;
                    else
                        state_d = S_SLOT;
                end
            end
            S_DONE: begin
                dig_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (ABORT) begin
            state_d = S_IDLE;
            dig_d   = '0;
            cnt_d   = '0;
            hs_d    = 1'b0;
        end
    end

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= M_SLOW;
            ndig_q  <= '0;
            dig_q   <= '0;
            wc_q    <= '0;
            pos_q   <= '0;
            cnt_q   <= '0;
            hs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            ndig_q  <= ndig_d;
            dig_q   <= dig_d;
            wc_q    <= wc_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            hs_q    <= hs_d;
        end
    end

    assign READY    = (state_q == S_IDLE);
    assign OE       = (state_q == S_LOAD);
    assign OG       = (state_q == S_GATE);
    assign DSTB     = (state_q == S_GATE) && (cnt_q == 7'd3);
    assign DONE     = (state_q == S_DONE);
    assign DREQ     = ((state_q == S_SLOT) && need_hs && !hs_q) || (state_q == S_HOLD);
    assign SLOW_OUT = !READY && (mode_q == M_SLOW);
    assign FAST_OUT = !READY && (mode_q == M_FAST);
    assign IN       = !READY && (mode_q == M_IN);
    assign DIG      = dig_q;
endmodule

// File: tb/tb_io_xfer_seq.sv
// Bench for io_xfer_seq: drum timing generator, DACK responder, event monitor and directed/random commands.
module tb_io_xfer_seq;
    logic       CLOCK = 1'b0;
    logic       rst;
    logic       T0, T29, W0, START, DACK, ABORT;
    logic [1:0] MODE;
    logic [4:0] NDIG;
    logic       OE, OG, SLOW_OUT, FAST_OUT, IN, READY, DREQ, DSTB, DONE;
    logic [4:0] DIG;

    io_xfer_seq dut (
        .CLOCK(CLOCK), .rst(rst), .T0(T0), .T29(T29), .W0(W0), .START(START),
        .MODE(MODE), .NDIG(NDIG), .DACK(DACK), .ABORT(ABORT), .OE(OE), .OG(OG),
        .SLOW_OUT(SLOW_OUT), .FAST_OUT(FAST_OUT), .IN(IN), .READY(READY),
        .DREQ(DREQ), .DSTB(DSTB), .DONE(DONE), .DIG(DIG)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;

    // drum reference: bit time, word and band position as plain counters
    bit run = 1'b0;
    int tb_bit = 0, tb_word = 0, m_pos = 0;

    bit dack_tie = 1'b0;
    int dack_delay = 0;

    // monitor records for the current command
    int cyc = 0;
    int og_pos[$], og_cyc[$], dstb_pos[$], oe_pos[$], oe_cyc[$];
    int oe_word0, oe_bit0, done_cnt, hs_cnt, hs_bad, dreq_bad, lvl_bad, dig_bad;
    bit exp_hs;
    logic [2:0] exp_lvl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic timing_gen();
        forever begin
            @(posedge CLOCK); #1;
            if (!run) begin
                tb_bit = 0; tb_word = 0; m_pos = 0;
            end else begin
                tb_bit++;
                if (tb_bit == 30) begin
                    tb_bit  = 0;
                    tb_word = (tb_word + 1) % 108;
                end
                m_pos = (tb_bit == 0 && tb_word == 0) ? 0 : (m_pos + 1) % 116;
            end
            T0  = (tb_bit == 0);
            T29 = (tb_bit == 29);
            W0  = (tb_bit == 0 && tb_word == 0);
        end
    endtask

    task automatic dack_drv();
        int wait_c = 0;
        forever begin
            @(posedge CLOCK); #2;
            if (dack_tie) DACK = 1'b1;
            else if (DACK) DACK = 1'b0;
            else if (DREQ) begin
                if (wait_c >= dack_delay) begin
                    DACK = 1'b1;
                    wait_c = 0;
                end else wait_c++;
            end else wait_c = 0;
        end
    endtask

    task automatic monitor();
        bit prev_hs = 1'b0;
        forever begin
            @(negedge CLOCK);
            if (!rst) begin
                cyc++;
                if (OG) begin
                    if (og_pos.size() % 4 == 0 && exp_hs && hs_cnt < og_pos.size() / 4 + 1) hs_bad++;
                    if (int'(DIG) != m_pos / 4) dig_bad++;
                    og_pos.push_back(m_pos);
                    og_cyc.push_back(cyc);
                end
                if (DSTB) dstb_pos.push_back(m_pos);
                if (OE) begin
                    if (oe_pos.size() == 0) begin
                        oe_word0 = tb_word;
                        oe_bit0  = tb_bit;
                    end
                    oe_pos.push_back(m_pos);
                    oe_cyc.push_back(cyc);
                end
                if (DONE) done_cnt++;
                if (prev_hs && DREQ) dreq_bad++;
                prev_hs = DREQ && DACK;
                if (DREQ && DACK) hs_cnt++;
                if (READY ? ({SLOW_OUT, FAST_OUT, IN} != 3'b000) : ({SLOW_OUT, FAST_OUT, IN} != exp_lvl)) lvl_bad++;
            end else prev_hs = 1'b0;
        end
    endtask

    task automatic clear_mon();
        og_pos.delete(); og_cyc.delete(); dstb_pos.delete(); oe_pos.delete(); oe_cyc.delete();
        oe_word0 = -1; oe_bit0 = -1;
        done_cnt = 0; hs_cnt = 0; hs_bad = 0; dreq_bad = 0; lvl_bad = 0; dig_bad = 0;
    endtask

    task automatic pulse_start(input logic [1:0] md, input logic [4:0] nd, input bit ab);
        @(posedge CLOCK); #1;
        START = 1'b1; MODE = md; NDIG = nd; ABORT = ab;
        @(posedge CLOCK); #1;
        START = 1'b0; ABORT = 1'b0;
    endtask

    task automatic set_expect(input logic [1:0] md);
        exp_hs  = (md != 2'b01);
        exp_lvl = (md == 2'b00) ? 3'b100 : (md == 2'b01) ? 3'b010 : 3'b001;
    endtask

    // One full command, then compare what the monitor saw against the rules for that mode.
    task automatic run_cmd(input string tag, input logic [1:0] md, input logic [4:0] nd,
                           input bit tie, input int dly);
        int n, waited, seq_bad, dst_bad, gap_bad, oe_bad, first_og, last_og, first_oe, last_oe;
        n = (nd == 5'd0) ? 29 : int'(nd);
        clear_mon();
        dack_tie = tie;
        dack_delay = dly;
        set_expect(md);
        pulse_start(md, nd, 1'b0);
        waited = 0;
        while (done_cnt == 0 && waited < 20000) begin
            @(posedge CLOCK);
            waited++;
        end
        chk({tag, "_in_budget"}, waited < 20000, 1);
        repeat (4) @(posedge CLOCK);
        @(negedge CLOCK);
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_og_cycles"}, og_pos.size(), 4 * n);
        seq_bad = 0; gap_bad = 0;
        foreach (og_pos[i]) begin
            if (og_pos[i] != i) seq_bad++;
            if (i % 4 != 0 && og_cyc[i] != og_cyc[i-1] + 1) gap_bad++;
        end
        chk({tag, "_og_pos_seq"}, seq_bad, 0);
        chk({tag, "_og_window_gaps"}, gap_bad, 0);
        chk({tag, "_dstb_count"}, dstb_pos.size(), n);
        dst_bad = 0;
        foreach (dstb_pos[i]) if (dstb_pos[i] != 4 * i + 3) dst_bad++;
        chk({tag, "_dstb_pos"}, dst_bad, 0);
        chk({tag, "_oe_cycles"}, oe_pos.size(), 116);
        chk({tag, "_oe_word"}, oe_word0, 0);
        chk({tag, "_oe_bit"}, oe_bit0, 0);
        oe_bad = 0;
        foreach (oe_pos[i]) if (oe_pos[i] != i) oe_bad++;
        chk({tag, "_oe_pos_seq"}, oe_bad, 0);
        first_og = og_cyc.size() > 0 ? og_cyc[0] : -1;
        last_og  = og_cyc.size() > 0 ? og_cyc[og_cyc.size()-1] : -1;
        first_oe = oe_cyc.size() > 0 ? oe_cyc[0] : -1;
        last_oe  = oe_cyc.size() > 0 ? oe_cyc[oe_cyc.size()-1] : -1;
        if (md == 2'b10) chk({tag, "_oe_after_digits"}, first_oe > last_og, 1);
        else             chk({tag, "_oe_before_digits"}, last_oe < first_og && last_oe > 0, 1);
        if (md == 2'b01) chk({tag, "_fast_span"}, last_og - first_og, 4 * n - 1);
        chk({tag, "_handshake"}, hs_bad + dreq_bad, 0);
        chk({tag, "_mode_levels"}, lvl_bad, 0);
        chk({tag, "_dig_track"}, dig_bad, 0);
        chk({tag, "_idle_after"}, {READY, DIG}, {1'b1, 5'd0});
    endtask

    initial begin
        int waited;
        logic [1:0] md;
        logic [4:0] nd;
        rst = 1'b1; START = 1'b0; ABORT = 1'b0; DACK = 1'b0; MODE = 2'b00; NDIG = 5'd0;
        T0 = 1'b1; T29 = 1'b0; W0 = 1'b1;
        exp_hs = 1'b0; exp_lvl = 3'b000;
        clear_mon();
        fork
            timing_gen();
            dack_drv();
            monitor();
        join_none

        repeat (3) @(negedge CLOCK);
        chk("rst_ready", READY, 1);
        chk("rst_outputs", {OE, OG, SLOW_OUT, FAST_OUT, IN, DREQ, DSTB, DONE, DIG}, 0);
        rst = 1'b0;
        run = 1'b1;

        run_cmd("slow2", 2'b00, 5'd2, 1'b1, 0);
        run_cmd("fast29", 2'b01, 5'd0, 1'b0, 0);
        run_cmd("in3", 2'b10, 5'd3, 1'b0, 50);
        run_cmd("in_hold", 2'b10, 5'd2, 1'b0, 140);
        for (int k = 0; k < 3; k++) begin
            md = 2'($urandom_range(0, 2));
            nd = (md == 2'b01) ? 5'($urandom_range(0, 29)) : 5'($urandom_range(1, 4));
            run_cmd($sformatf("rnd%0d", k), md, nd, 1'b0, $urandom_range(0, 60));
        end

        // illegal mode is ignored
        clear_mon();
        pulse_start(2'b11, 5'd5, 1'b0);
        @(negedge CLOCK);
        chk("mode11_ready", READY, 1);
        chk("mode11_quiet", {SLOW_OUT, FAST_OUT, IN, OE, DREQ, DIG}, 0);

        // START while busy is ignored, then ABORT+START during LOAD
        clear_mon();
        set_expect(2'b00);
        pulse_start(2'b00, 5'd1, 1'b0);
        repeat (3) @(posedge CLOCK);
        pulse_start(2'b01, 5'd5, 1'b0);
        @(negedge CLOCK);
        chk("busy_start_levels", {SLOW_OUT, FAST_OUT, IN, READY}, 4'b1000);
        waited = 0;
        while (!OE && waited < 5000) begin
            @(negedge CLOCK);
            waited++;
        end
        chk("abort_reached_load", OE, 1);
        pulse_start(2'b01, 5'd3, 1'b1);
        @(negedge CLOCK);
        chk("abort_idle", {READY, OE, DIG}, {1'b1, 1'b0, 5'd0});
        repeat (200) @(negedge CLOCK);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_still_idle", {READY, OE, OG}, 3'b100);
        chk("abort_levels", lvl_bad, 0);

        // asynchronous reset in the middle of a gate
        clear_mon();
        set_expect(2'b01);
        pulse_start(2'b01, 5'd0, 1'b0);
        waited = 0;
        while (!(OG && DIG != 5'd0) && waited < 6000) begin
            @(negedge CLOCK);
            waited++;
        end
        chk("rst_reached_gate", OG, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_gate_og", OG, 0);
        chk("rst_gate_ready_dig", {READY, DIG}, {1'b1, 5'd0});
        run = 1'b0;
        repeat (3) @(negedge CLOCK);
        rst = 1'b0;
        run = 1'b1;
        repeat (50) @(negedge CLOCK);
        chk("rst_no_done", done_cnt, 0);
        chk("rst_idle_after", {READY, OG, OE}, 3'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
